// File: rtl/rangefinder_pkg.sv
// Shared types and constants for the rangefinder sweep controller.
package rangefinder_pkg;
  localparam int unsigned FB_W           = 640;
  localparam int unsigned FB_H           = 480;
  localparam int unsigned FB_PIXELS      = FB_W * FB_H;
  localparam int unsigned STEP_FIRST_DEF = 44;
  localparam int unsigned STEP_LAST_DEF  = 725;
  localparam int unsigned STEP_W         = 11;
  localparam int unsigned ADDR_W         = 19;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_REQUEST = 3'd2,
    S_COLLECT = 3'd3,
    S_PROC    = 3'd4,
    S_DONE    = 3'd5
  } scan_state_e;
endpackage

// File: rtl/fb_clear_engine.sv
// Frame-buffer clear address generator and the registered BRAM write-port mux
// shared between the clear sweep and the datapath plot writes.
module fb_clear_engine
  import rangefinder_pkg::*;
#(
  parameter int unsigned FB_PIXELS = rangefinder_pkg::FB_PIXELS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_en,
  input  logic [ADDR_W-1:0] plot_addr,
  input  logic              plot_we,
  input  logic [7:0]        plot_din,
  output logic              clear_last,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_we,
  output logic [7:0]        bram_din
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_PIXELS - 1);

  if (FB_PIXELS > (1 << ADDR_W) || FB_PIXELS == 0) begin : g_depth_chk
    $error("FB_PIXELS does not fit the BRAM address width");
  end

  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic              bram_we_q, bram_we_d;
  logic [7:0]        bram_din_q, bram_din_d;

  assign clear_last = clear_en && (clr_addr_q == LAST_ADDR);

  always_comb begin
    clr_addr_d  = '0;
    bram_addr_d = plot_addr;
    bram_we_d   = plot_we;
    bram_din_d  = plot_din;
    // The clear sweep owns the port outright; plot writes during it are lost.
    if (clear_en) begin
      clr_addr_d  = clear_last ? '0 : clr_addr_q + 1'b1;
      bram_addr_d = clr_addr_q;
      bram_we_d   = 1'b1;
      bram_din_d  = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_addr_q  <= '0;
      bram_addr_q <= '0;
      bram_we_q   <= 1'b0;
      bram_din_q  <= '0;
    end else begin
      clr_addr_q  <= clr_addr_d;
      bram_addr_q <= bram_addr_d;
      bram_we_q   <= bram_we_d;
      bram_din_q  <= bram_din_d;
    end
  end

  assign bram_addr = bram_addr_q;
  assign bram_we   = bram_we_q;
  assign bram_din  = bram_din_q;
endmodule

// File: rtl/rangefinder_scan_ctrl.sv
// Sweep sequencer: clear frame, request scan, pace samples into the datapath,
// with a one-entry skid buffer and a retrying watchdog.
module rangefinder_scan_ctrl
  import rangefinder_pkg::*;
#(
  parameter int unsigned FB_PIXELS  = rangefinder_pkg::FB_PIXELS,
  parameter int unsigned STEP_FIRST = rangefinder_pkg::STEP_FIRST_DEF,
  parameter int unsigned STEP_LAST  = rangefinder_pkg::STEP_LAST_DEF,
  parameter int unsigned PROC_GAP   = 52,
  parameter int unsigned TX_PULSE   = 4,
  parameter int unsigned WD_LIMIT   = 1000000,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned CONTINUOUS = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              sample_valid,
  input  logic [15:0]       sample_data,
  output logic              transmit,
  output logic              proc_enable,
  output logic [15:0]       proc_data,
  output logic [STEP_W-1:0] proc_step,
  input  logic [ADDR_W-1:0] plot_addr,
  input  logic              plot_we,
  input  logic [7:0]        plot_din,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_we,
  output logic [7:0]        bram_din,
  output logic              busy,
  output logic              scan_done,
  output logic              error,
  output logic              overrun
);
  localparam int unsigned WD_W  = $clog2(WD_LIMIT + 1);
  localparam int unsigned GAP_W = $clog2(PROC_GAP + 1);
  localparam int unsigned TX_W  = $clog2(TX_PULSE + 1);
  localparam int unsigned RT_W  = $clog2(MAX_RETRY + 2);

  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(WD_LIMIT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(PROC_GAP - 1);
  localparam logic [TX_W-1:0]   TX_LAST   = TX_W'(TX_PULSE - 1);
  localparam logic [RT_W-1:0]   RT_MAX    = RT_W'(MAX_RETRY);
  localparam logic [STEP_W-1:0] STEP_FST  = STEP_W'(STEP_FIRST);
  localparam logic [STEP_W-1:0] STEP_LST  = STEP_W'(STEP_LAST);

  if (STEP_LAST >= 2048 || STEP_FIRST > STEP_LAST) begin : g_step_chk
    $error("step range does not fit the 11-bit step index");
  end
  if (PROC_GAP == 0 || TX_PULSE == 0 || WD_LIMIT == 0) begin : g_cnt_chk
    $error("PROC_GAP, TX_PULSE and WD_LIMIT must be non-zero");
  end

  scan_state_e       state_q, state_d;
  logic              start_q, start_d;
  logic [TX_W-1:0]   tx_cnt_q, tx_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic [RT_W-1:0]   retry_q, retry_d;
  logic [STEP_W-1:0] proc_step_q, proc_step_d;
  logic [15:0]       proc_data_q, proc_data_d;
  logic              proc_enable_q, proc_enable_d;
  logic              skid_full_q, skid_full_d;
  logic [15:0]       skid_data_q, skid_data_d;
  logic              error_q, error_d;
  logic              overrun_q, overrun_d;
  logic              start_edge, issue, clear_last;

  assign start_d    = start;
  assign start_edge = start & ~start_q;

  always_comb begin
    state_d       = state_q;
    tx_cnt_d      = tx_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    wd_cnt_d      = wd_cnt_q;
    retry_d       = retry_q;
    proc_step_d   = proc_step_q;
    proc_data_d   = proc_data_q;
    proc_enable_d = 1'b0;
    skid_full_d   = skid_full_q;
    skid_data_d   = skid_data_q;
    error_d       = error_q;
    overrun_d     = overrun_q;
    issue         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          error_d   = 1'b0;
          overrun_d = 1'b0;
          retry_d   = '0;
          state_d   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (clear_last) begin
          tx_cnt_d = '0;
          state_d  = S_REQUEST;
        end
      end
      S_REQUEST: begin
        if (tx_cnt_q == TX_LAST) begin
          proc_step_d = STEP_FST;
          wd_cnt_d    = '0;
          state_d     = S_COLLECT;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      S_COLLECT: begin
        // A buffered sample goes first; a concurrent new one takes its slot.
        if (skid_full_q) begin
          issue       = 1'b1;
          proc_data_d = skid_data_q;
          skid_full_d = sample_valid;
          if (sample_valid) skid_data_d = sample_data;
        end else if (sample_valid) begin
          issue       = 1'b1;
          proc_data_d = sample_data;
        end else if (wd_cnt_q == WD_LAST) begin
          if (retry_q < RT_MAX) begin
            retry_d     = retry_q + 1'b1;
            proc_step_d = STEP_FST;
            tx_cnt_d    = '0;
            state_d     = S_REQUEST;
          end else begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
        if (issue) begin
          proc_enable_d = 1'b1;
          gap_cnt_d     = '0;
          state_d       = S_PROC;
        end
      end
      S_PROC: begin
        if (sample_valid) begin
          if (skid_full_q) begin
            overrun_d = 1'b1;
          end else begin
            skid_full_d = 1'b1;
            skid_data_d = sample_data;
          end
        end
        if (gap_cnt_q == GAP_LAST) begin
          if (proc_step_q == STEP_LST) begin
            state_d = S_DONE;
          end else begin
            proc_step_d = proc_step_q + 1'b1;
            wd_cnt_d    = '0;
            state_d     = S_COLLECT;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        skid_full_d = 1'b0;
        state_d     = (CONTINUOUS != 0) ? S_CLEAR : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      start_q       <= 1'b0;
      tx_cnt_q      <= '0;
      gap_cnt_q     <= '0;
      wd_cnt_q      <= '0;
      retry_q       <= '0;
      proc_step_q   <= '0;
      proc_data_q   <= '0;
      proc_enable_q <= 1'b0;
      skid_full_q   <= 1'b0;
      skid_data_q   <= '0;
      error_q       <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_q       <= start_d;
      tx_cnt_q      <= tx_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      wd_cnt_q      <= wd_cnt_d;
      retry_q       <= retry_d;
      proc_step_q   <= proc_step_d;
      proc_data_q   <= proc_data_d;
      proc_enable_q <= proc_enable_d;
      skid_full_q   <= skid_full_d;
      skid_data_q   <= skid_data_d;
      error_q       <= error_d;
      overrun_q     <= overrun_d;
    end
  end

  fb_clear_engine #(
    .FB_PIXELS (FB_PIXELS)
  ) u_clear (
    .clk        (clk),
    .reset      (reset),
    .clear_en   (state_q == S_CLEAR),
    .plot_addr  (plot_addr),
    .plot_we    (plot_we),
    .plot_din   (plot_din),
    .clear_last (clear_last),
    .bram_addr  (bram_addr),
    .bram_we    (bram_we),
    .bram_din   (bram_din)
  );

  assign transmit    = (state_q == S_REQUEST);
  assign busy        = (state_q != S_IDLE);
  assign scan_done   = (state_q == S_DONE);
  assign proc_enable = proc_enable_q;
  assign proc_data   = proc_data_q;
  assign proc_step   = proc_step_q;
  assign error       = error_q;
  assign overrun     = overrun_q;
endmodule

// File: tb/tb_rangefinder_scan_ctrl.sv
// Directed bench: scoreboards of expected BRAM writes and datapath issues,
// plus hand-computed timing checks on a small frame and short sweep.
module tb_rangefinder_scan_ctrl;
  localparam int unsigned P_FB = 16, P_SF = 0, P_SL = 3, P_GAP = 4;
  localparam int unsigned P_TX = 2, P_WD = 20, P_MR = 1;

  logic        clk = 1'b0;
  logic        reset, start, sample_valid, plot_we;
  logic [15:0] sample_data;
  logic [18:0] plot_addr;
  logic [7:0]  plot_din;
  logic        transmit, proc_enable, bram_we, busy, scan_done, error, overrun;
  logic [15:0] proc_data;
  logic [10:0] proc_step;
  logic [18:0] bram_addr;
  logic [7:0]  bram_din;

  always #5 clk = ~clk;

  rangefinder_scan_ctrl #(
    .FB_PIXELS(P_FB), .STEP_FIRST(P_SF), .STEP_LAST(P_SL), .PROC_GAP(P_GAP),
    .TX_PULSE(P_TX), .WD_LIMIT(P_WD), .MAX_RETRY(P_MR), .CONTINUOUS(0)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .sample_valid(sample_valid),
    .sample_data(sample_data), .transmit(transmit), .proc_enable(proc_enable),
    .proc_data(proc_data), .proc_step(proc_step), .plot_addr(plot_addr),
    .plot_we(plot_we), .plot_din(plot_din), .bram_addr(bram_addr),
    .bram_we(bram_we), .bram_din(bram_din), .busy(busy), .scan_done(scan_done),
    .error(error), .overrun(overrun)
  );

  typedef struct { logic [18:0] addr; logic [7:0] din; } wr_t;
  typedef struct { logic [15:0] data; logic [10:0] step; } pe_t;

  int  n_tests = 0, n_fail = 0, cyc = 0;
  int  tx_hi = 0, done_n = 0;
  bit  mon_on = 1'b0;
  logic tx_prev = 1'b0;
  wr_t exp_wr[$];
  pe_t exp_pe[$];
  int  en_cyc[$], tx_rise[$], sv_q[$];
  wr_t mw;
  pe_t mp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard compare: every BRAM write and every datapath issue is matched
  // in order against what the current scenario says must happen.
  always @(negedge clk) begin
    if (mon_on) begin
      if (bram_we === 1'b1) begin
        if (exp_wr.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL bram_extra_write: got addr %0d din %0h, expected no write", bram_addr, bram_din);
        end else begin
          mw = exp_wr.pop_front();
          chk("bram_addr", 64'(bram_addr), 64'(mw.addr));
          chk("bram_din", 64'(bram_din), 64'(mw.din));
        end
      end
      if (proc_enable === 1'b1) begin
        en_cyc.push_back(cyc);
        if (exp_pe.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL proc_extra_enable: got data %0h step %0d, expected no enable", proc_data, proc_step);
        end else begin
          mp = exp_pe.pop_front();
          chk("proc_data", 64'(proc_data), 64'(mp.data));
          chk("proc_step", 64'(proc_step), 64'(mp.step));
        end
      end
      if (transmit === 1'b1) tx_hi++;
      if (transmit === 1'b1 && tx_prev !== 1'b1) tx_rise.push_back(cyc);
      tx_prev = transmit;
      if (scan_done === 1'b1) done_n++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sv_pulse(input logic [15:0] d);
    sample_valid = 1'b1;
    sample_data  = d;
    @(posedge clk);
    #1;
    sv_q.push_back(cyc);
    sample_valid = 1'b0;
  endtask

  // sel 0: transmit==val, 1: busy==val, 2: bram write at address val
  task automatic wait_until(input int sel, input int val, input int budget, input string nm);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < budget && !hit; k++) begin
      @(negedge clk);
      case (sel)
        0:       hit = (transmit === val[0]);
        1:       hit = (busy === val[0]);
        default: hit = (bram_we === 1'b1) && (bram_addr === val[18:0]);
      endcase
    end
    n_tests++;
    if (!hit) begin
      n_fail++;
      $display("FAIL wait_%s: condition not reached, required within %0d cycles", nm, budget);
    end
  endtask

  task automatic clear_logs();
    tx_hi = 0; done_n = 0;
    tx_rise.delete(); en_cyc.delete(); sv_q.delete();
  endtask

  task automatic push_clear();
    wr_t w;
    for (int a = 0; a < int'(P_FB); a++) begin
      w.addr = 19'(a);
      w.din  = 8'h00;
      exp_wr.push_back(w);
    end
  endtask

  task automatic push_pe(input logic [15:0] d, input int s);
    pe_t p;
    p.data = d;
    p.step = 11'(s);
    exp_pe.push_back(p);
  endtask

  function automatic logic [63:0] all_outs();
    return {3'd0, transmit, proc_enable, proc_data, proc_step, bram_addr,
            bram_we, bram_din, busy, scan_done, error, overrun};
  endfunction

  initial begin
    #300000;
    n_fail++;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    wr_t w;
    reset = 1'b1; start = 1'b0; sample_valid = 1'b0; sample_data = '0;
    plot_addr = '0; plot_we = 1'b0; plot_din = '0;
    idle(3);
    chk("reset_outputs", all_outs(), 64'd0);
    reset = 1'b0;
    mon_on = 1'b1;
    idle(1);

    // Clear, request, then a clean four-sample sweep.
    clear_logs();
    push_clear();
    push_pe(16'h3031, 0); push_pe(16'h3032, 1); push_pe(16'h3033, 2); push_pe(16'h3034, 3);
    start = 1'b1;
    idle(1);
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("no_write_first_clear_cycle", 64'(bram_we), 64'd0);
    idle(1);
    chk("first_clear_we", 64'(bram_we), 64'd1);
    chk("first_clear_addr", 64'(bram_addr), 64'd0);
    wait_until(0, 1, 40, "tx_rise");
    chk("last_clear_with_tx_addr", 64'(bram_addr), 64'd15);
    chk("busy_in_request", 64'(busy), 64'd1);
    wait_until(0, 0, 10, "tx_fall");
    sv_pulse(16'h3031);
    for (int i = 0; i < 3; i++) begin
      idle(9);
      sv_pulse(16'h3032 + 16'(i));
    end
    wait_until(1, 0, 40, "sweep_end");
    chk("sweep_done_pulses", 64'(done_n), 64'd1);
    chk("sweep_tx_high_cycles", 64'(tx_hi), 64'd2);
    chk("sweep_tx_pulses", 64'(tx_rise.size()), 64'd1);
    chk("sweep_enables", 64'(en_cyc.size()), 64'd4);
    if (en_cyc.size() == 4) begin
      chk("sweep_enable_latency", 64'(en_cyc[0]), 64'(sv_q[0]));
      for (int i = 1; i < 4; i++) chk("sweep_enable_spacing", 64'(en_cyc[i] - en_cyc[i-1]), 64'd10);
    end
    chk("sweep_hold_data", 64'(proc_data), 64'h3034);
    chk("sweep_hold_step", 64'(proc_step), 64'd3);
    chk("sweep_no_overrun", 64'(overrun), 64'd0);
    chk("sweep_pending_issues", 64'(exp_pe.size()), 64'd0);
    chk("sweep_pending_writes", 64'(exp_wr.size()), 64'd0);

    // Skid buffering and overrun.
    clear_logs();
    start = 1'b0; idle(2);
    push_clear();
    push_pe(16'h4141, 0); push_pe(16'h4242, 1); push_pe(16'h4343, 2); push_pe(16'h4444, 3);
    start = 1'b1;
    wait_until(0, 1, 40, "skid_tx_rise");
    wait_until(0, 0, 10, "skid_tx_fall");
    sv_pulse(16'h4141);
    idle(1);
    sv_pulse(16'h4242);
    idle(7);
    sv_pulse(16'h4343);
    idle(1);
    sv_pulse(16'h4444);
    chk("overrun_before_third", 64'(overrun), 64'd0);
    sv_pulse(16'h4545);
    chk("overrun_after_third", 64'(overrun), 64'd1);
    wait_until(1, 0, 40, "skid_end");
    chk("skid_enables", 64'(en_cyc.size()), 64'd4);
    if (en_cyc.size() == 4) begin
      chk("skid_direct_latency", 64'(en_cyc[0]), 64'(sv_q[0]));
      chk("skid_refill_latency", 64'(en_cyc[2]), 64'(sv_q[2]));
      for (int i = 1; i < 4; i++) chk("skid_enable_spacing", 64'(en_cyc[i] - en_cyc[i-1]), 64'd5);
    end
    chk("skid_overrun_sticky", 64'(overrun), 64'd1);
    chk("skid_done_pulses", 64'(done_n), 64'd1);
    chk("skid_pending_issues", 64'(exp_pe.size()), 64'd0);

    // Watchdog retry then error, with plot-write arbitration.
    clear_logs();
    start = 1'b0; idle(2);
    push_clear();
    start = 1'b1;
    idle(1);
    chk("overrun_cleared_on_start", 64'(overrun), 64'd0);
    idle(3);
    plot_addr = 19'd5; plot_din = 8'hAA; plot_we = 1'b1;
    idle(4);
    plot_we = 1'b0;
    wait_until(0, 1, 40, "wd_tx_rise");
    wait_until(0, 0, 10, "wd_tx_fall");
    plot_addr = 19'd7; plot_din = 8'hFF; plot_we = 1'b1;
    w.addr = 19'd7; w.din = 8'hFF;
    exp_wr.push_back(w);
    @(posedge clk); #1;
    plot_we = 1'b0;
    chk("plot_pass_we", 64'(bram_we), 64'd1);
    chk("plot_pass_addr", 64'(bram_addr), 64'd7);
    chk("plot_pass_din", 64'(bram_din), 64'hFF);
    wait_until(1, 0, 100, "wd_end");
    chk("wd_tx_pulses", 64'(tx_rise.size()), 64'd2);
    if (tx_rise.size() == 2) chk("wd_retry_gap", 64'(tx_rise[1] - tx_rise[0]), 64'd22);
    chk("wd_tx_high_cycles", 64'(tx_hi), 64'd4);
    chk("wd_error", 64'(error), 64'd1);
    chk("wd_step", 64'(proc_step), 64'd0);
    chk("wd_no_enables", 64'(en_cyc.size()), 64'd0);
    chk("wd_pending_writes", 64'(exp_wr.size()), 64'd0);

    // Ignored start edge while busy, then reset mid-clear and restart.
    clear_logs();
    start = 1'b0; idle(2);
    push_clear();
    start = 1'b1;
    idle(4);
    start = 1'b0;
    idle(1);
    start = 1'b1;
    wait_until(2, 9, 30, "clear_addr9");
    reset = 1'b1;
    @(posedge clk); #1;
    chk("reset_mid_clear_outputs", all_outs(), 64'd0);
    chk("reset_dropped_writes", 64'(exp_wr.size()), 64'd6);
    exp_wr.delete();
    start = 1'b0;
    idle(1);
    reset = 1'b0;
    idle(2);
    chk("idle_after_reset", 64'(busy), 64'd0);
    push_clear();
    start = 1'b1;
    idle(2);
    chk("restart_clear_we", 64'(bram_we), 64'd1);
    chk("restart_clear_addr", 64'(bram_addr), 64'd0);
    wait_until(0, 1, 40, "restart_tx");
    wait_until(1, 0, 100, "restart_end");
    chk("restart_pending_writes", 64'(exp_wr.size()), 64'd0);
    chk("restart_error", 64'(error), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
